pwm_scan_ctrl: RTL and testbench

//  Row-scan sequencer for the multi-channel PWM LED datapath. Accepts channel

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_gcount.sv | 43 ++++
 rtl/pwm_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pwm_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM row-scan datapath.
//   scan_st_e : scan sequencer states
//   duty_t    : duty / count word at the default width
package pwm_pkg;

  localparam int unsigned DefDwidth   = 8;
  localparam int unsigned DefNch      = 16;
  localparam int unsigned DefNrow     = 8;
  localparam int unsigned DefBlankCyc = 4;

  typedef logic [DefDwidth-1:0] duty_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LATCH,
    PWM,
    BLNK
  } scan_st_e;

endpackage

// File: rtl/pwm_gcount.sv
// Global PWM counter shared by all channel PWM blocks.
//   clk     : clock
//   clr     : asynchronous active-high reset
//   en_i    : advance count by one
//   sclr_i  : synchronous clear (wins over en_i)
//   count_o : current count
//   wrap_o  : count is at its final value 2**DWIDTH-1
module pwm_gcount
  import pwm_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en_i,
  input  logic              sclr_i,
  output logic [DWIDTH-1:0] count_o,
  output logic              wrap_o
);

  logic [DWIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (sclr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = (count_q == {DWIDTH{1'b1}});

endmodule

// File: rtl/pwm_scan_ctrl.sv
// Row-scan sequencer: buffers channel duties from a valid/ready stream into a
// shadow buffer, latches them onto the PWM data bus, runs the global count with
// an hsync pulse, then blanks and advances the row.
//   clk, clr     : clock, asynchronous active-high reset
//   start, cont  : begin a frame (IDLE only); repeat frames
//   wr_*         : duty word stream, channel order 0..NCH-1
//   data_q       : latched duties, channel i at [i*DWIDTH +: DWIDTH]
//   count, hsync : global PWM count and its count==0 start pulse
//   blank, row   : row driver blanking and active row
//   busy, frame_done, underrun : status (underrun is sticky per frame)
module pwm_scan_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DWIDTH    = DefDwidth,
  parameter int unsigned NCH       = DefNch,
  parameter int unsigned NROW      = DefNrow,
  parameter int unsigned BLANK_CYC = DefBlankCyc
) (
  input  logic                                   clk,
  input  logic                                   clr,
  input  logic                                   start,
  input  logic                                   cont,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [DWIDTH-1:0]                      wr_data,
  output logic [NCH*DWIDTH-1:0]                  data_q,
  output logic [DWIDTH-1:0]                      count,
  output logic                                   hsync,
  output logic                                   blank,
  output logic [((NROW > 1) ? $clog2(NROW) : 1)-1:0] row,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   underrun
);

  localparam int unsigned PtrW = $clog2(NCH + 1);
  localparam int unsigned RowW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int unsigned BcW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [PtrW-1:0] NchP    = PtrW'(NCH);
  localparam logic [RowW-1:0] RowLast = RowW'(NROW - 1);
  localparam logic [BcW-1:0]  BcLast  = BcW'(BLANK_CYC - 1);

  scan_st_e state_q, state_d;

  logic [DWIDTH-1:0]     shadow_q [NCH];
  logic [DWIDTH-1:0]     shadow_d [NCH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [NCH*DWIDTH-1:0] lat_q, lat_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [BcW-1:0]        bcnt_q, bcnt_d;
  logic                  hsync_q, hsync_d;
  logic                  blank_q, blank_d;
  logic                  busy_q, busy_d;
  logic                  fdone_q, fdone_d;
  logic                  under_q, under_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_fire;
  logic                  cnt_wrap;

  // Count is held at 0 outside PWM so PWM blocks clearing on count==data keep
  // a zero-duty channel dark.
  pwm_gcount #(
    .DWIDTH (DWIDTH)
  ) u_gcount (
    .clk    (clk),
    .clr    (clr),
    .en_i   (state_q == PWM),
    .sclr_i (state_q != PWM),
    .count_o(count),
    .wrap_o (cnt_wrap)
  );

  assign wr_fire = wr_valid && wr_ready_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    wptr_d   = wptr_q;
    lat_d    = lat_q;
    row_d    = row_q;
    bcnt_d   = bcnt_q;
    fdone_d  = 1'b0;
    under_d  = under_q;

    if (wr_fire) begin
      for (int i = 0; i < NCH; i++) begin
        if (wptr_q == PtrW'(i)) begin
          shadow_d[i] = wr_data;
        end
      end
      wptr_d = wptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          under_d = 1'b0;
          row_d   = '0;
        end
      end
      FILL: begin
        if (wptr_q == NchP) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        // wr_ready is low here, so no write competes with the pointer reset.
        for (int i = 0; i < NCH; i++) begin
          lat_d[i*DWIDTH +: DWIDTH] = shadow_q[i];
        end
        wptr_d  = '0;
        state_d = PWM;
      end
      PWM: begin
        if (cnt_wrap) begin
          state_d = BLNK;
          bcnt_d  = '0;
        end
      end
      BLNK: begin
        if (bcnt_q == BcLast) begin
          if (row_q == RowLast) begin
            fdone_d = 1'b1;
            row_d   = '0;
            state_d = cont ? FILL : IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = FILL;
          end
          // A word landing on this very clock still counts toward the next row.
          if (wptr_d != NchP) begin
            under_d = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view.
    blank_d    = (state_d != PWM);
    busy_d     = (state_d != IDLE);
    hsync_d    = (state_d == PWM) && (state_q != PWM);
    wr_ready_d = busy_d && (state_d != LATCH) && (wptr_d != NchP);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      shadow_q   <= '{default: '0};
      wptr_q     <= '0;
      lat_q      <= '0;
      row_q      <= '0;
      bcnt_q     <= '0;
      hsync_q    <= 1'b0;
      blank_q    <= 1'b1;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      under_q    <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      wptr_q     <= wptr_d;
      lat_q      <= lat_d;
      row_q      <= row_d;
      bcnt_q     <= bcnt_d;
      hsync_q    <= hsync_d;
      blank_q    <= blank_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      under_q    <= under_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign data_q     = lat_q;
  assign row        = row_q;
  assign hsync      = hsync_q;
  assign blank      = blank_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign underrun   = under_q;
  assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// Directed bench for pwm_scan_ctrl with DWIDTH=4, NCH=4, NROW=2, BLANK_CYC=2.
module tb_pwm_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        cont;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_data;
  logic [15:0] data_q;
  logic [3:0]  count;
  logic        hsync;
  logic        blank;
  logic [0:0]  row;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int hs;

  always #5 clk = ~clk;

  pwm_scan_ctrl #(
    .DWIDTH   (4),
    .NCH      (4),
    .NROW     (2),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .cont      (cont),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .data_q    (data_q),
    .count     (count),
    .hsync     (hsync),
    .blank     (blank),
    .row       (row),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    wr_valid = 1'b1;
    wr_data = a; step();
    wr_data = b; step();
    wr_data = c; step();
    wr_data = d; step();
    wr_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; cont = 1'b0; wr_valid = 1'b0; wr_data = '0;
    #2 clr = 1'b1;
    #2;
    check("rst_count", count, 0);
    check("rst_blank", blank, 1);
    check("rst_busy", busy, 0);
    check("rst_hsync", hsync, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_data_q", data_q, 0);
    check("rst_row", row, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    clr = 1'b0;

    // No writes accepted in IDLE.
    wr_valid = 1'b1; wr_data = 4'd7;
    step();
    check("idle_wr_ready", wr_ready, 0);
    step();
    wr_valid = 1'b0;

    // 1: first row with words 1,2,3,15.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_fill_blank", blank, 1);
    check("t1_fill_ready", wr_ready, 1);
    push4(4'd1, 4'd2, 4'd3, 4'd15);
    check("t1_full_ready", wr_ready, 0);
    step();  // LATCH
    check("t1_latch_blank", blank, 1);
    check("t1_latch_data", data_q, 16'h0000);
    check("t1_latch_hsync", hsync, 0);
    step();  // PWM, count 0
    check("t1_hsync", hsync, 1);
    check("t1_count0", count, 0);
    check("t1_blank0", blank, 0);
    check("t1_data_q", data_q, 16'hF321);
    for (int i = 1; i < 16; i++) begin
      step();
      check("t1_count", count, 64'(i));
      check("t1_hsync_low", hsync, 0);
    end
    step();
    check("t1_blnk1_blank", blank, 1);
    check("t1_blnk1_count", count, 0);
    step();
    check("t1_blnk2_row", row, 0);
    step();
    check("t1_row1", row, 1);
    check("t2_underrun", underrun, 1);
    check("t2_blank", blank, 1);

    // 2: stall in FILL until the shadow fills.
    run(3);
    check("t2_stall_count", count, 0);
    check("t2_stall_blank", blank, 1);
    check("t2_stall_hsync", hsync, 0);
    check("t2_stall_ready", wr_ready, 1);

    // 3: five words queued with wr_valid held.
    wr_valid = 1'b1;
    wr_data = 4'd5; step();
    wr_data = 4'd6; step();
    wr_data = 4'd7; step();
    wr_data = 4'd8; step();
    wr_data = 4'd9;
    check("t3_ready_full", wr_ready, 0);
    step();  // LATCH
    check("t3_ready_latch", wr_ready, 0);
    step();  // PWM
    check("t3_hsync", hsync, 1);
    check("t3_data_q", data_q, 16'h8765);
    check("t3_row", row, 1);
    check("t3_ready_pwm", wr_ready, 1);
    check("t3_underrun_sticky", underrun, 1);
    step();  // word 9 into ch0
    wr_valid = 1'b0;
    run(17);
    check("t3_end_busy", busy, 0);
    check("t3_end_frame_done", frame_done, 1);
    check("t3_end_row", row, 0);
    step();
    check("t3_frame_done_pulse", frame_done, 0);

    // 4/6: continuous frames, start ignored while busy, zero duty.
    cont = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_underrun_clr", underrun, 0);
    check("t4_busy", busy, 1);
    wr_valid = 1'b1;
    wr_data = 4'd10; step();
    wr_data = 4'd11; step();
    wr_data = 4'd12; step();
    wr_valid = 1'b0;
    step();
    step();
    check("t4_data_q_ch0_carry", data_q, 16'hCBA9);
    check("t4_hsync", hsync, 1);
    start = 1'b1;
    wr_valid = 1'b1; wr_data = 4'd0;
    step();
    start = 1'b0;
    wr_data = 4'd4;  step();
    wr_data = 4'd0;  step();
    wr_data = 4'd13; step();
    wr_valid = 1'b0;
    check("t6_start_ignored_count", count, 4);
    check("t6_start_ignored_blank", blank, 0);
    check("t6_full_ready", wr_ready, 0);
    hs = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      hs += int'(hsync);
    end
    check("t6_no_extra_hsync", 64'(hs), 0);
    check("t6_row1", row, 1);
    check("t6_no_underrun", underrun, 0);
    step();
    step();
    check("t6_data_q", data_q, 16'hD040);
    check("t6_lane0_zero", data_q[3:0], 0);
    check("t6_hsync_row1", hsync, 1);
    push4(4'd1, 4'd1, 4'd1, 4'd1);
    run(14);
    check("t4_frame_done", frame_done, 1);
    check("t4_row_wrap", row, 0);
    check("t4_busy_cont", busy, 1);
    check("t4_underrun", underrun, 0);
    step();
    check("t4_frame_done_low", frame_done, 0);
    step();
    check("t4_f2_hsync", hsync, 1);
    check("t4_f2_data_q", data_q, 16'h1111);
    cont = 1'b0;
    push4(4'd2, 4'd2, 4'd2, 4'd2);
    run(14);
    check("t4_f2_row1", row, 1);
    check("t4_f2_no_underrun", underrun, 0);
    step();
    step();
    check("t4_f2_data_q_r1", data_q, 16'h2222);
    run(18);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_frame_done", frame_done, 1);
    check("t4_stop_underrun", underrun, 1);

    // 5: asynchronous clear mid-PWM.
    start = 1'b1;
    step();
    start = 1'b0;
    push4(4'd3, 4'd3, 4'd3, 4'd3);
    step();
    step();
    run(7);
    check("t5_count7", count, 7);
    check("t5_pwm_blank", blank, 0);
    #2 clr = 1'b1;
    #1;
    check("t5_clr_count", count, 0);
    check("t5_clr_blank", blank, 1);
    check("t5_clr_hsync", hsync, 0);
    check("t5_clr_busy", busy, 0);
    check("t5_clr_data_q", data_q, 0);
    check("t5_clr_ready", wr_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    step();
    check("t5_post_busy", busy, 0);
    check("t5_post_blank", blank, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
